// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 phase sequencer: runs enabled phase engines in index order through
// start/done handshakes and muxes the active engine onto the single S-memory port.
module rc4_phase_sequencer #(
   parameter int unsigned N_PHASES  = 3,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned TIMEOUT_W = 16,
   parameter int unsigned TIMEOUT   = 4096,
   localparam int unsigned CUR_W    = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [N_PHASES-1:0]          phase_en,
   input  logic [N_PHASES-1:0]          phase_done,
   input  logic [N_PHASES*ADDR_W-1:0]   phase_addr,
   input  logic [N_PHASES*DATA_W-1:0]   phase_wdata,
   input  logic [N_PHASES-1:0]          phase_wren,
   output logic [N_PHASES-1:0]          phase_start,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic                         mem_wren,
   output logic [CUR_W-1:0]             cur_phase,
   output logic                         busy,
   output logic                         done,
   output logic                         error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state, state_nxt;
   logic [CUR_W-1:0]      cur_nxt;
   logic [N_PHASES-1:0]   en_q, en_nxt;
   logic [TIMEOUT_W-1:0]  wdog, wdog_nxt;

   logic [CUR_W-1:0]      first_idx;
   logic [CUR_W-1:0]      next_idx;
   logic                  next_found;
   logic                  timeout_hit;
   logic [TIMEOUT_W-1:0]  wdog_inc;

   // State, phase index, latched enable mask and watchdog
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cur_phase <= '0;
         en_q      <= '0;
         wdog      <= '0;
      end else begin
         state     <= state_nxt;
         cur_phase <= cur_nxt;
         en_q      <= en_nxt;
         wdog      <= wdog_nxt;
      end
   end

   // Lowest enabled phase of a new run, and next enabled phase above the current one
   always_comb begin
      first_idx  = '0;
      next_idx   = '0;
      next_found = 1'b0;
      for (int i = int'(N_PHASES) - 1; i >= 0; i--) begin
         if (phase_en[i]) begin
            first_idx = CUR_W'(i);
         end
         if (en_q[i] && (CUR_W'(i) > cur_phase)) begin
            next_idx   = CUR_W'(i);
            next_found = 1'b1;
         end
      end
   end

   // Watchdog saturates rather than wrapping so a disabled watchdog never aliases
   always_comb begin
      wdog_inc    = (&wdog) ? wdog : wdog + TIMEOUT_W'(1);
      timeout_hit = (TIMEOUT != 0) && (wdog == TIMEOUT_W'(TIMEOUT - 1));
   end

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur_phase;
      en_nxt    = en_q;
      wdog_nxt  = wdog;

      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               en_nxt = phase_en;
               if (phase_en == '0) begin
                  state_nxt = S_DONE;
               end else begin
                  cur_nxt   = first_idx;
                  wdog_nxt  = '0;
                  state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (phase_done[cur_phase]) begin
               if (next_found) begin
                  cur_nxt   = next_idx;
                  state_nxt = S_GAP;
               end else begin
                  state_nxt = S_DONE;
               end
            end else if (timeout_hit) begin
               state_nxt = S_ERROR;
            end else begin
               wdog_nxt = wdog_inc;
            end
         end
         S_GAP: begin
            wdog_nxt  = '0;
            state_nxt = S_RUN;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Abort overrides start and done from any state
      if (abort) begin
         state_nxt = S_IDLE;
         cur_nxt   = '0;
         wdog_nxt  = '0;
      end
   end

   // Status and engine starts decode the registered state; memory mux only live in RUN
   always_comb begin
      phase_start = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wren    = 1'b0;
      busy        = (state == S_RUN) || (state == S_GAP);
      done        = (state == S_DONE);
      error       = (state == S_ERROR);
      if (state == S_RUN) begin
         phase_start = N_PHASES'(1) << cur_phase;
         mem_addr    = phase_addr[32'(cur_phase) * ADDR_W +: ADDR_W];
         mem_wdata   = phase_wdata[32'(cur_phase) * DATA_W +: DATA_W];
         mem_wren    = phase_wren[cur_phase];
      end
   end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Bench for rc4_phase_sequencer: responder engines with programmable latency, random
// memory/noise traffic, and a trace-level reference model of the expected phase schedule.
module tb_rc4_phase_sequencer;

   localparam int N  = 3;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  phase_en = '0;
   logic [2:0]  phase_done;
   logic [23:0] phase_addr = '0;
   logic [23:0] phase_wdata = '0;
   logic [2:0]  phase_wren = '0;
   logic [2:0]  phase_start;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wren;
   logic [1:0]  cur_phase;
   logic        busy;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   int         lat [N];
   int         cnt [N];
   logic [2:0] noise = '0;

   typedef struct {
      logic [2:0] ps;
      logic       busy;
      logic       done;
      logic       error;
      logic [1:0] cur;
   } exp_t;

   exp_t q[$];

   rc4_phase_sequencer #(
      .N_PHASES(N), .ADDR_W(8), .DATA_W(8), .TIMEOUT_W(16), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .phase_en(phase_en), .phase_done(phase_done), .phase_addr(phase_addr),
      .phase_wdata(phase_wdata), .phase_wren(phase_wren), .phase_start(phase_start),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .cur_phase(cur_phase), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Engine i answers done on its lat[i]-th started cycle (lat 0 = never); other bits get noise
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) cnt[i] <= phase_start[i] ? cnt[i] + 1 : 0;
   end

   always_comb begin
      phase_done = noise & ~phase_start;
      for (int i = 0; i < N; i++)
         if (phase_start[i] && lat[i] != 0 && cnt[i] == lat[i] - 1) phase_done[i] = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected per-cycle schedule: enabled phases in order, one idle gap between them
   function automatic void build(input logic [2:0] en);
      bit         first = 1'b1;
      int         n;
      logic [1:0] lastp = '0;
      q.delete();
      for (int p = 0; p < N; p++) begin
         if (en[p]) begin
            if (!first) q.push_back('{ps: 3'b000, busy: 1'b1, done: 1'b0, error: 1'b0, cur: 2'(p)});
            first = 1'b0;
            n = (lat[p] == 0 || lat[p] > TO) ? TO : lat[p];
            for (int c = 0; c < n; c++)
               q.push_back('{ps: 3'(1 << p), busy: 1'b1, done: 1'b0, error: 1'b0, cur: 2'(p)});
            if (lat[p] == 0 || lat[p] > TO) begin
               repeat (3) q.push_back('{ps: 3'b000, busy: 1'b0, done: 1'b0, error: 1'b1, cur: 2'(p)});
               return;
            end
            lastp = 2'(p);
         end
      end
      repeat (3) q.push_back('{ps: 3'b000, busy: 1'b0, done: 1'b1, error: 1'b0, cur: lastp});
   endfunction

   task automatic drive_rand(input bit allow_start);
      phase_addr  = 24'($urandom);
      phase_wdata = 24'($urandom);
      phase_wren  = 3'($urandom);
      noise       = 3'($urandom);
      phase_en    = 3'($urandom);
      start       = allow_start ? 1'($urandom) : 1'b0;
   endtask

   task automatic check_cycle(input exp_t e);
      logic [7:0] ea, ed;
      logic       ew;
      ea = '0; ed = '0; ew = 1'b0;
      if (e.ps != 3'b000) begin
         ea = phase_addr[32'(e.cur) * 8 +: 8];
         ed = phase_wdata[32'(e.cur) * 8 +: 8];
         ew = phase_wren[e.cur];
      end
      chk("phase_start", 32'(phase_start), 32'(e.ps));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("error", 32'(error), 32'(e.error));
      if (e.busy) chk("cur_phase", 32'(cur_phase), 32'(e.cur));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ed));
      chk("mem_wren", 32'(mem_wren), 32'(ew));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_start"}, 32'(phase_start), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_cur"}, 32'(cur_phase), 32'd0);
      chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_mwren"}, 32'(mem_wren), 32'd0);
   endtask

   // Start a run and follow it for 'cycles' checked cycles (-1 = whole trace)
   task automatic run(input logic [2:0] en, input int l0, input int l1, input int l2,
                      input int cycles);
      int n;
      lat[0] = l0; lat[1] = l1; lat[2] = l2;
      build(en);
      n = (cycles < 0 || cycles > q.size()) ? q.size() : cycles;
      @(posedge clk); #1;
      drive_rand(1'b0);
      phase_en = en;
      start    = 1'b1;
      @(posedge clk); #1;
      for (int j = 0; j < n; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         drive_rand(q[j].busy);
         @(negedge clk);
         check_cycle(q[j]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      noise = '0;
   endtask

   task automatic cancel(input bit use_rst, input string tag);
      drive_rand(1'b0);
      start = 1'b1;
      if (use_rst) rst = 1'b0;
      else abort = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b1;
      abort = 1'b0;
      start = 1'b0;
      phase_wren = 3'b111;
      @(negedge clk);
      check_idle(tag);
   endtask

   initial begin
      lat[0] = 0; lat[1] = 0; lat[2] = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      phase_wren = 3'b111;
      @(negedge clk);
      check_idle("reset");
      rst = 1'b1;

      run(3'b111, 10, 10, 10, -1);
      run(3'b101, 10, 10, 10, -1);
      run(3'b000, 5, 5, 5, -1);
      run(3'b001, 0, 3, 3, -1);
      run(3'b001, 3, 3, 3, -1);
      run(3'b011, 16, 1, 1, -1);
      run(3'b110, 4, 17, 2, -1);
      run(3'b010, 2, 20, 2, -1);

      run(3'b111, 5, 5, 5, 8);
      cancel(1'b0, "abort_mid");
      run(3'b111, 5, 5, 5, 8);
      cancel(1'b1, "rst_mid");
      run(3'b011, 2, 3, 1, -1);
      cancel(1'b0, "abort_done");

      for (int r = 0; r < 25; r++)
         run(3'($urandom), $urandom_range(0, 18), $urandom_range(0, 18),
             $urandom_range(0, 18), -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
